// File: rtl/multi_carrier_gen.sv
// Phase-staggered triangle/sawtooth carrier generator for N_CH channels with a
// configurable done delay. Define CARRIER_SYNC_IN_EN to add the sync_in re-alignment input.
module multi_carrier_gen #(
  parameter int N_CH     = 4,
  parameter int CW       = 16,
  parameter int DONE_DLY = 11
) (
  input  logic                 clk,
  input  logic                 rst_user,
  input  logic                 sta_user,
  input  logic                 sta,
  input  logic                 mode,
  input  logic [CW-1:0]        period_max,
`ifdef CARRIER_SYNC_IN_EN
  input  logic                 sync_in,
`endif
  output logic [N_CH*CW-1:0]   carrier_out,
  output logic [N_CH-1:0]      dir_out,
  output logic                 sync_out,
  output logic                 done_sig,
  output logic                 busy,
  output logic                 cfg_err
);
  localparam int LG = $clog2(N_CH);
  localparam int PW = CW + 1;
  localparam int OW = CW + 6;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       p_q, p_d, p_act;
  logic                mode_q, mode_d, mode_act;
  logic                cfg_err_q, cfg_err_d;
  logic                sync_q, sync_d;
  logic [DONE_DLY-1:0] done_q, done_d;
  logic [PW-1:0]       two_p, last_ph;
  logic                load_ok, realign, step;
  logic                sync_in_w;

`ifdef CARRIER_SYNC_IN_EN
  assign sync_in_w = sync_in;
`else
  assign sync_in_w = 1'b0;
`endif

  // Priority: load (sta_user) > realign (sync_in) > step (sta); nothing moves in IDLE.
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    mode_d    = mode_q;
    cfg_err_d = cfg_err_q;
    load_ok   = sta_user && (period_max != '0);
    realign   = !sta_user && (state_q == S_RUN) && sync_in_w;
    step      = !sta_user && !sync_in_w && (state_q == S_RUN) && sta;
    if (sta_user) begin
      if (load_ok) begin
        state_d   = S_RUN;
        p_d       = period_max;
        mode_d    = mode;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
    // Outputs are computed from the configuration in force after this edge.
    p_act    = load_ok ? period_max : p_q;
    mode_act = load_ok ? mode : mode_q;
    two_p    = {p_act, 1'b0};
    last_ph  = two_p - PW'(1);
    done_d   = DONE_DLY'({done_q, sta});
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [PW-1:0] ph_q, ph_d, off;
      logic [CW-1:0] car_q, car_d;
      logic          dir_q, dir_d;

      always_comb begin
        off  = PW'((OW'(gi) * OW'(two_p)) >> LG);
        ph_d = ph_q;
        if (load_ok || realign) begin
          ph_d = off;
        end else if (step) begin
          ph_d = (ph_q == last_ph) ? '0 : ph_q + PW'(1);
        end
        car_d = '0;
        dir_d = 1'b0;
        if (state_d == S_RUN) begin
          if (mode_act) begin
            car_d = CW'(ph_d >> 1);
            dir_d = 1'b1;
          end else begin
            car_d = (ph_d <= {1'b0, p_act}) ? CW'(ph_d) : CW'(two_p - ph_d);
            dir_d = (ph_d < {1'b0, p_act});
          end
        end
      end

      always_ff @(posedge clk or posedge rst_user) begin
        if (rst_user) begin
          ph_q  <= '0;
          car_q <= '0;
          dir_q <= 1'b0;
        end else begin
          ph_q  <= ph_d;
          car_q <= car_d;
          dir_q <= dir_d;
        end
      end

      assign carrier_out[gi*CW +: CW] = car_q;
      assign dir_out[gi]              = dir_q;

      // Channel 0 is the sync reference: pulse when its phase wraps on a step.
      if (gi == 0) begin : g_sync
        assign sync_d = step && (ph_q == last_ph);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst_user) begin
    if (rst_user) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      mode_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      sync_q    <= 1'b0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      mode_q    <= mode_d;
      cfg_err_q <= cfg_err_d;
      sync_q    <= sync_d;
      done_q    <= done_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign cfg_err  = cfg_err_q;
  assign sync_out = sync_q;
  assign done_sig = done_q[DONE_DLY-1];
endmodule
